// File: rtl/bist_ctrl_p_pkg.sv
// rtl/bist_ctrl_p_pkg.sv - state encoding and default sizing shared by the BIST controller files
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  localparam int N_DEF = 9;
  localparam int M_DEF = 8;

  // Seed index needs at least one bit even for a single seed.
  function automatic int seed_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/bist_ctrl_p_if.sv
// rtl/bist_ctrl_p_if.sv - request/status bundle between a BIST requester and the controller
interface bist_ctrl_p_if
  import bist_pkg::*;
#(
  parameter int SEED_W = seed_w(M_DEF)
);

  logic              start;
  logic              abort;
  logic              sig_ok;
  logic              out;
  logic [SEED_W-1:0] seed_idx;
  logic              running;
  logic              bist_end;
  logic              pass;

  modport master (
    output start, abort, sig_ok,
    input  out, seed_idx, running, bist_end, pass
  );

  modport slave (
    input  start, abort, sig_ok,
    output out, seed_idx, running, bist_end, pass
  );

endinterface

// File: rtl/bist_ctrl_p_rise_det.sv
// rtl/bist_ctrl_p_rise_det.sv - 0->1 detector on a sampled level input
module rise_det (
  input  logic CLK,
  input  logic RESET_N,
  input  logic D,
  output logic RISE
);

  logic start_q;

  // Resetting to 1 means a level already high at reset release is not an edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      start_q <= 1'b1;
    end else begin
      start_q <= D;
    end
  end

  assign RISE = D & ~start_q;

endmodule

// File: rtl/bist_ctrl_p.sv
// rtl/bist_ctrl_p.sv - BIST sequencer: M seeds of N vectors, one signature check, sticky result
module bist_ctrl_p
  import bist_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int M     = M_DEF,
  parameter int CNT_W = $clog2((N + 1) * M + 1)
) (
  input logic          CLK,
  input logic          RESET_N,
  bist_ctrl_p_if.slave bus
);

  localparam int SEED_W = seed_w(M);
  localparam int PH_W   = (N > 0) ? $clog2(N + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((N + 1) * M - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(N);
  localparam logic [PH_W-1:0]  PH_PRE   = PH_W'(N - 1);

  bist_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PH_W-1:0]   phase_q;
  logic [SEED_W-1:0] seed_q;
  logic              out_q;
  logic              running_q;
  logic              end_q;
  logic              pass_q;
  logic              start_rise;

  rise_det u_rise_det (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .D       (bus.start),
    .RISE    (start_rise)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      seed_q    <= '0;
      out_q     <= 1'b1;
      running_q <= 1'b0;
      end_q     <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_rise) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            phase_q   <= '0;
            seed_q    <= '0;
            out_q     <= 1'b1;
            running_q <= 1'b1;
            end_q     <= 1'b0;
            pass_q    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            out_q     <= 1'b1;
            end_q     <= 1'b0;
            pass_q    <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            // Seed index is left at M-1 so it never wraps during a test.
            state_q   <= ST_CHECK;
            running_q <= 1'b0;
            out_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (phase_q == PH_LAST) begin
              phase_q <= '0;
              seed_q  <= seed_q + SEED_W'(1);
            end else begin
              phase_q <= phase_q + PH_W'(1);
            end
            // Strobe goes low in the cycle whose phase will be N.
            out_q <= (phase_q != PH_PRE);
          end
        end
        ST_CHECK: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            end_q   <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            state_q <= ST_DONE;
            end_q   <= 1'b1;
            pass_q  <= bus.sig_ok;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out      = out_q;
  assign bus.seed_idx = seed_q;
  assign bus.running  = running_q;
  assign bus.bist_end = end_q;
  assign bus.pass     = pass_q;

endmodule
